timer_run_control: RTL

//  Front-end control for the four-digit down-count timer. Synchronises and debounces two raw

---
 rtl/timer_run_control_if.sv | 31 +++
 rtl/timer_run_control.sv | 131 +++++++++++++
 2 files changed

// File: rtl/timer_run_control_if.sv
// Button, timer-status and timer-control signals of the run-control block.
// master drives the buttons and zero flag; slave is the controller.
interface timer_run_control_if;
  logic       btn_start;
  logic       btn_clear;
  logic       timer_zero;
  logic       timer_enable;
  logic       timer_reset;
  logic [1:0] state;
  logic       expired_led;

  modport master (
    output btn_start,
    output btn_clear,
    output timer_zero,
    input  timer_enable,
    input  timer_reset,
    input  state,
    input  expired_led
  );

  modport slave (
    input  btn_start,
    input  btn_clear,
    input  timer_zero,
    output timer_enable,
    output timer_reset,
    output state,
    output expired_led
  );
endinterface

// File: rtl/timer_run_control.sv
// Run/pause/done control for the down-count timer with debounced
// start/clear buttons and a blinking expired LED.
module timer_run_control #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DEBOUNCE_WIDTH  = 20,
  parameter int BLINK_CYCLES    = 25000000,
  parameter int BLINK_WIDTH     = 25
) (
  input logic               clk,
  input logic               reset,
  timer_run_control_if.slave io
);
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [DEBOUNCE_WIDTH-1:0] DB_MAX =
    DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLINK_WIDTH-1:0] BL_MAX =
    BLINK_WIDTH'(BLINK_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] level;
  logic [1:0] level_d;
  logic [1:0] press;
  logic [1:0][DEBOUNCE_WIDTH-1:0] db_cnt;

  logic start;
  logic clear;

  state_t                 state;
  logic                   trst;
  logic                   led;
  logic [BLINK_WIDTH-1:0] bl_cnt;

  assign raw   = {io.btn_clear, io.btn_start};
  assign start = press[0];
  assign clear = press[1];

  // bit 0 = start, bit 1 = clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      db_cnt  <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DEBOUNCE_WIDTH'(1);
        end
      end
    end
  end

  // clear beats the zero flag, which beats start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      trst   <= 1'b0;
      led    <= 1'b0;
      bl_cnt <= '0;
    end else begin
      trst <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear) begin
            trst <= 1'b1;
          end else if (start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (clear) begin
            state <= IDLE;
            trst  <= 1'b1;
          end else if (io.timer_zero) begin
            state  <= DONE;
            led    <= 1'b1;
            bl_cnt <= '0;
          end else if (start) begin
            state <= PAUSE;
          end
        end
        PAUSE: begin
          if (clear) begin
            state <= IDLE;
            trst  <= 1'b1;
          end else if (start) begin
            state <= RUN;
          end
        end
        DONE: begin
          if (clear) begin
            state  <= IDLE;
            trst   <= 1'b1;
            led    <= 1'b0;
            bl_cnt <= '0;
          end else if (bl_cnt == BL_MAX) begin
            led    <= ~led;
            bl_cnt <= '0;
          end else begin
            bl_cnt <= bl_cnt + BLINK_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.timer_enable = (state == RUN);
  assign io.timer_reset  = trst;
  assign io.state        = state;
  assign io.expired_led  = led;
endmodule
